// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART transmitter.
// A small sequencer drains it over the tx_start/tx_ready handshake.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_ready
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic              wr_ok;
    logic              pop;

    // Decisions use registered full/empty, so a write into an empty
    // FIFO cannot be popped on the same edge.
    assign wr_ok = wr_en && !full;
    assign pop   = (state == IDLE) && !empty && tx_ready;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_comb begin
        count_nxt = count;
        unique case ({wr_ok, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (pop) state_nxt = START;
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!tx_ready) state_nxt = WAIT_DONE;
            WAIT_DONE: if (tx_ready) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_start <= (state_nxt == START);
            overflow <= wr_en && full;
            count    <= count_nxt;
            full     <= (count_nxt == FULL_CNT);
            empty    <= (count_nxt == '0);
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_data <= mem[rd_ptr];
            end
        end
    end

endmodule
